// File: rtl/stream_lane_packer_if.sv
// Handshake bundle for the lane packer: the narrow input beat stream and
// the wide packed output stream. The packer sits on the slave modport; the
// producer/consumer side (or a testbench) uses the master modport.
interface stream_lane_packer_if #(
   parameter int ACT_DATA_WIDTH = 8,
   parameter int IN_LANES       = 4,
   parameter int OUT_LANES      = 16,
   parameter int ADDR_WIDTH     = 32
);
   localparam int RATIO_MAX = OUT_LANES / IN_LANES;
   localparam int CW        = $clog2(RATIO_MAX + 1);

   // Input beat stream (narrow)
   logic                                     in_valid;
   logic                                     in_ready;
   logic [IN_LANES-1:0][ACT_DATA_WIDTH-1:0]  in_word;
   logic [ADDR_WIDTH-1:0]                    in_addr;

   // Output word stream (wide)
   logic                                     out_valid;
   logic                                     out_ready;
   logic [OUT_LANES-1:0][ACT_DATA_WIDTH-1:0] out_word;
   logic [ADDR_WIDTH-1:0]                    out_addr;
   logic [CW-1:0]                            out_beats;

   // Producer of beats and consumer of packed words
   modport master (
      output in_valid, in_word, in_addr, out_ready,
      input  in_ready, out_valid, out_word, out_addr, out_beats
   );

   // The packer itself
   modport slave (
      input  in_valid, in_word, in_addr, out_ready,
      output in_ready, out_valid, out_word, out_addr, out_beats
   );
endinterface

// File: rtl/stream_lane_packer.sv
// Narrow-to-wide activation stream packer. Collects eff_ratio beats of
// IN_LANES lanes into one OUT_LANES word, with valid/ready on both sides,
// a runtime ratio latched per group, and flush of partial groups (unused
// lanes read as zero). The address of the first beat travels with the word.
module stream_lane_packer #(
   parameter int ACT_DATA_WIDTH = 8,
   parameter int IN_LANES       = 4,
   parameter int OUT_LANES      = 16,
   parameter int ADDR_WIDTH     = 32,
   localparam int RATIO_MAX     = OUT_LANES / IN_LANES,
   localparam int CW            = $clog2(RATIO_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CW-1:0]         cfg_ratio,
   input  logic                  flush,
   output logic                  busy,
   stream_lane_packer_if.slave   bus
);

   typedef enum logic {S_EMPTY, S_FILL} state_t;
   typedef logic [OUT_LANES-1:0][ACT_DATA_WIDTH-1:0] word_t;

   // Group state
   state_t                state;
   logic [CW-1:0]         cnt;          // beats already held in gather_q
   logic [CW-1:0]         ratio_q;      // ratio latched on the first beat
   logic [ADDR_WIDTH-1:0] addr_q;       // address of the first beat
   word_t                 gather_q;     // lanes of the beats held so far
   logic                  flush_pend;   // flush waiting for a free output

   // Output registers
   logic                  out_valid_q;
   word_t                 out_word_q;
   logic [ADDR_WIDTH-1:0] out_addr_q;
   logic [CW-1:0]         out_beats_q;
   logic                  busy_q;

   // Combinational helpers
   logic [CW-1:0]         ratio_cfg;
   logic [CW-1:0]         cur_ratio;
   logic                  flush_req;
   logic                  last_idx;
   logic                  last_beat_pending;
   logic                  out_free;
   logic                  accept;
   logic                  emit_beat;
   logic                  emit_flush;
   logic                  emit;
   word_t                 merged;
   logic [CW-1:0]         beats_next;
   logic [ADDR_WIDTH-1:0] grp_addr;

   // Clamp the requested ratio into [1, RATIO_MAX]; zero means one beat.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      ratio_cfg = cfg_ratio;
      if (cfg_ratio == '0)
         ratio_cfg = CW'(1);
      else if (cfg_ratio > CW'(RATIO_MAX))
         ratio_cfg = CW'(RATIO_MAX);
   end

   // A new group uses the live ratio; a group in progress keeps its latched one.
   assign cur_ratio = (state == S_EMPTY) ? ratio_cfg : ratio_q;

   // A pending flush behaves like a flush held high until it is serviced.
   assign flush_req         = flush || flush_pend;
   assign last_idx          = (cnt == cur_ratio - CW'(1));
   assign last_beat_pending = last_idx || flush_req;
   assign out_free          = !out_valid_q || bus.out_ready;

   // Only a beat that would produce a word is held off by a stalled output.
   assign bus.in_ready = !(last_beat_pending && out_valid_q && !bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // A word goes out on a completing/flushing beat, or on a lone flush in FILL.
   assign emit_beat  = accept && last_beat_pending;
   assign emit_flush = !accept && flush_req && (state == S_FILL) && out_free;
   assign emit       = emit_beat || emit_flush;

   assign beats_next = emit_beat ? cnt + CW'(1) : cnt;
   assign grp_addr   = (state == S_EMPTY) ? bus.in_addr : addr_q;

   // Gather buffer with the current beat dropped into its lane slot.
   always_comb begin
      merged = gather_q;
      for (int k = 0; k < RATIO_MAX; k++) begin
         if (accept && cnt == CW'(k))
            merged[k*IN_LANES +: IN_LANES] = bus.in_word;
      end
   end

   // Group FSM, gather buffer and output register in one sequential block.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the gather buffer is reset (not just the control) because unfilled lanes must read as zero on a flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_EMPTY;
         cnt         <= '0;
         ratio_q     <= CW'(1);
         addr_q      <= '0;
         gather_q    <= '0;
         flush_pend  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_addr_q  <= '0;
         out_beats_q <= '0;
      end else begin
         // Output register: load a new word, or retire the old one.
         if (emit) begin
            out_valid_q <= 1'b1;
            out_word_q  <= merged;
            out_addr_q  <= grp_addr;
            out_beats_q <= beats_next;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         // Group tracking.
         if (emit) begin
            state      <= S_EMPTY;
            busy_q     <= 1'b0;
            cnt        <= '0;
            gather_q   <= '0;
            flush_pend <= 1'b0;
         end else begin
            if (accept) begin
               if (state == S_EMPTY) begin
                  ratio_q <= ratio_cfg;
                  addr_q  <= bus.in_addr;
               end
               state    <= S_FILL;
               busy_q   <= 1'b1;
               cnt      <= cnt + CW'(1);
               gather_q <= merged;
            end
            // A flush that cannot be serviced now waits; repeats are absorbed.
            if (flush && state == S_FILL)
               flush_pend <= 1'b1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_word  = out_word_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_beats = out_beats_q;
   assign busy          = busy_q;

endmodule
